// File: rtl/multiplier_taint_pkg.sv
// Shared types and helpers for the taint-tracking shift-add multiplier controller.
package multiplier_taint_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic taint_or(input logic a, input logic b);
    return a | b;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Bit-index counter for the multiplier controller: clear, increment, and a
// terminal flag that is high while the index sits on the last operand bit.
module mult_iter_counter
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = 1024,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_controller_taint_track.sv
// Control FSM for the shift-add multiplier with a 1-bit taint shadow on every output.
// Define MULT_CTRL_CONST_TIME_EN for constant-time operation (ADD always followed by SHIFT).
module multiplier_controller_taint_track
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             mrld,
  output logic             mdld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             mrld_t,
  output logic             mdld_t,
  output logic             rsclear_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t,
  output state_e           dbg_state
);

  localparam int IDX_W = idx_w(WIDTH);

  state_e           state_q, state_d;
  logic             state_t_q, state_t_d;
  logic             cnt_clr, cnt_inc, last;
  logic [IDX_W-1:0] idx;
  logic             mr_bit, data_t;

  mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (last)
  );

  assign mr_bit = multiplierReg[idx];
  assign data_t = taint_or(state_t_q, multiplierReg_t);

  always_comb begin
    state_d   = state_q;
    state_t_d = state_t_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    mrld      = 1'b0;
    mdld      = 1'b0;
    rsclear   = 1'b0;
    rsload    = 1'b0;
    rsshr     = 1'b0;
    rsload_t  = state_t_q;
    rsshr_t   = state_t_q;
    case (state_q)
      S_IDLE: begin
        // Whether we leave IDLE depends on start, so its taint becomes the control taint.
        state_t_d = start_t;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        mrld    = 1'b1;
        mdld    = 1'b1;
        rsclear = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_ADD;
      end
      S_ADD: begin
        rsload_t = data_t;
`ifdef MULT_CTRL_CONST_TIME_EN
        rsload  = mr_bit;
        state_d = S_SHIFT;
`else
        // Data-dependent timing: the multiplier taint leaks into control flow.
        rsshr_t   = data_t;
        state_t_d = data_t;
        if (mr_bit) begin
          rsload  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          rsshr   = 1'b1;
          cnt_inc = 1'b1;
          state_d = last ? S_DONE : S_ADD;
        end
`endif
      end
      S_SHIFT: begin
        rsshr   = 1'b1;
        cnt_inc = 1'b1;
        state_d = last ? S_DONE : S_ADD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      state_t_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      state_t_q <= state_t_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign mrld_t    = state_t_q;
  assign mdld_t    = state_t_q;
  assign rsclear_t = state_t_q;
  assign busy_t    = state_t_q;
  assign done_t    = state_t_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multiplier_controller_taint_track.sv
// Directed bench for multiplier_controller_taint_track (WIDTH=4) with a
// behavioural shift-add datapath attached; checks follow the build's mode macro.
module tb_multiplier_controller_taint_track;
  import multiplier_taint_pkg::*;

  localparam int W = 4;
`ifdef MULT_CTRL_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic         multiplierReg_t = 1'b0;
  logic [W-1:0] md_in = '0, mr_in = '0;
  logic [W-1:0] md_reg = '0, mr_reg = '0;
  logic [2*W:0] prod = '0;
  logic mrld, mdld, rsclear, rsload, rsshr, busy, done;
  logic mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t;
  state_e dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  multiplier_controller_taint_track #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
    .multiplierReg(mr_reg), .multiplierReg_t(multiplierReg_t),
    .mrld(mrld), .mdld(mdld), .rsclear(rsclear), .rsload(rsload), .rsshr(rsshr),
    .mrld_t(mrld_t), .mdld_t(mdld_t), .rsclear_t(rsclear_t), .rsload_t(rsload_t),
    .rsshr_t(rsshr_t), .busy(busy), .busy_t(busy_t), .done(done), .done_t(done_t),
    .dbg_state(dbg_state)
  );

  // datapath: accumulate into the upper half, shift the whole product right
  always_ff @(posedge clk) begin
    if (mrld) mr_reg <= mr_in;
    if (mdld) md_reg <= md_in;
    if (rsclear)     prod <= '0;
    else if (rsload) prod <= {({1'b0, prod[2*W-1:W]} + {1'b0, md_reg}), prod[W-1:0]};
    else if (rsshr)  prod <= prod >> 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after done.
  task automatic run_op(input logic [W-1:0] md, input logic [W-1:0] mr, input logic mr_t,
                        output int done_cyc, output logic [7:0] prod_o,
                        output logic done_t_o, output logic busy_t_done_o,
                        output logic load_busy_t_o, output logic load_ok,
                        output int add_rt, output int nonadd_rt,
                        output logic excl_bad, output logic taint_any, output logic post_ok);
    done_cyc = -1; prod_o = '0; done_t_o = 1'b0; busy_t_done_o = 1'b0;
    load_busy_t_o = 1'b1; load_ok = 1'b0; add_rt = 0; nonadd_rt = 0;
    excl_bad = 1'b0; taint_any = 1'b0;
    md_in = md; mr_in = mr; multiplierReg_t = mr_t; start = 1'b1; start_t = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        load_busy_t_o = busy_t;
        load_ok = mrld & mdld & rsclear & ~rsload & ~rsshr & busy & ~done;
      end
      if (dbg_state == S_ADD) add_rt += int'(rsload_t);
      else nonadd_rt += int'(rsload_t);
      if ((int'(rsclear) + int'(rsload) + int'(rsshr)) > 1) excl_bad = 1'b1;
      taint_any |= mrld_t | mdld_t | rsclear_t | rsload_t | rsshr_t | busy_t | done_t;
      if (done) begin
        done_cyc = c; prod_o = prod[7:0]; done_t_o = done_t; busy_t_done_o = busy_t;
        break;
      end
    end
    @(negedge clk);
    post_ok = ~done & ~busy & (dbg_state == S_IDLE);
  endtask

  int dc, add_rt, nonadd_rt, shift_cnt, li, di;
  int load_c[3], done_c[3];
  logic [7:0] p;
  logic dt, bt, lbt, lok, exb, tany, pok;
  int d_53, d_b, d_11, d_79, d_bb;

  initial begin
    d_53 = CT ? 10 : 8;
    d_b  = CT ? 10 : 9;
    d_11 = CT ? 10 : 7;
    d_79 = CT ? 10 : 8;
    d_bb = CT ? 10 : 8;

    // reset state
    #2;
    chk("rst_strobes", {25'd0, mrld, mdld, rsclear, rsload, rsshr, busy, done}, 32'd0);
    chk("rst_taints", {25'd0, mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clean md=3 mr=5
    run_op(4'd3, 4'd5, 1'b0, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("clean_done_cycle", dc, d_53);
    chk("clean_product", p, 8'd15);
    chk("clean_load_strobes", lok, 1'b1);
    chk("clean_taint_any", tany, 1'b0);
    chk("clean_excl", exb, 1'b0);
    chk("clean_done_pulse", pok, 1'b1);

    // md=3 mr=5 with multiplierReg_t
    run_op(4'd3, 4'd5, 1'b1, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("mrt_done_cycle", dc, d_53);
    chk("mrt_product", p, 8'd15);
    chk("mrt_rsload_t_add", add_rt, 4);
    chk("mrt_rsload_t_nonadd", nonadd_rt, CT ? 0 : 3);
    chk("mrt_done_t", dt, CT ? 1'b0 : 1'b1);
    chk("mrt_busy_t", bt, CT ? 1'b0 : 1'b1);

    // md=2 mr=1011 tainted, then clean restart
    run_op(4'd2, 4'b1011, 1'b1, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("b1011_done_cycle", dc, d_b);
    chk("b1011_product", p, 8'd22);
    chk("b1011_done_t", dt, CT ? 1'b0 : 1'b1);
    chk("b1011_excl", exb, 1'b0);
    run_op(4'd1, 4'd1, 1'b0, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("restart_load_busy_t", lbt, 1'b0);
    chk("restart_done_cycle", dc, d_11);
    chk("restart_product", p, 8'd1);

    // tainted idle cycle, then clean start
    start = 1'b0; start_t = 1'b1;
    @(posedge clk);
    #1 start_t = 1'b0;
    @(negedge clk);
    chk("idle_busy_t", busy_t, 1'b1);
    chk("idle_busy", busy, 1'b0);
    run_op(4'd1, 4'd1, 1'b0, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("idle_clean_load_busy_t", lbt, 1'b0);
    chk("idle_clean_done_t", dt, 1'b0);

    // reset during the second SHIFT
    md_in = 4'd3; mr_in = 4'd5; multiplierReg_t = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    shift_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dbg_state == S_SHIFT) shift_cnt++;
      if (shift_cnt == 2) break;
    end
    chk("midrst_reached_shift2", shift_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {25'd0, mrld, mdld, rsclear, rsload, rsshr, busy, done}, 32'd0);
    chk("midrst_taints", {25'd0, mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, busy_t, done_t}, 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd7, 4'd9, 1'b0, dc, p, dt, bt, lbt, lok, add_rt, nonadd_rt, exb, tany, pok);
    chk("postrst_done_cycle", dc, d_79);
    chk("postrst_product", p, 8'd63);

    // back-to-back with start held high
    for (int i = 0; i < 3; i++) begin
      load_c[i] = -1; done_c[i] = -1; exp_q.push_back(8'd15);
    end
    li = 0; di = 0;
    md_in = 4'd5; mr_in = 4'd3; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mrld && li < 3) begin
        load_c[li] = c; li++;
      end
      if (done && di < 3) begin
        done_c[di] = c; di++;
        chk("b2b_product", prod[7:0], exp_q.pop_front());
        if (di == 3) start = 1'b0;
      end
      if (di == 3 && c >= done_c[2] + 3) break;
    end
    chk("b2b_extra_load", li, 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_load_cycle", load_c[i], 1 + i * (d_bb + 1));
      chk("b2b_done_cycle", done_c[i], d_bb + i * (d_bb + 1));
    end
    chk("b2b_final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
